// File: rtl/store_pack.sv
// Store packer: checks store alignment, places bytes/halves onto their lanes, and
// holds up to two packed writes in a FIFO that presents its head to memory.
module store_pack #(
    parameter int bus_size = 32,
    parameter int depth    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [bus_size-1:0] st_addr,
    input  logic [bus_size-1:0] st_data,
    input  logic [1:0]          st_size,
    output logic                mem_req,
    output logic [bus_size-1:0] mem_addr,
    output logic [bus_size-1:0] mem_wdata,
    output logic [3:0]          mem_be,
    input  logic                mem_ack,
    output logic                misalign,
    output logic [bus_size-1:0] bad_addr
);

    typedef struct packed {
        logic [bus_size-1:0] addr;
        logic [bus_size-1:0] wdata;
        logic [3:0]          be;
    } entry_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    entry_t     fifo_q [depth];
    entry_t     fifo_d [depth];
    logic [1:0] count_q, count_d;
    logic       misalign_q, misalign_d;
    logic [bus_size-1:0] bad_addr_q, bad_addr_d;

    logic   accept, is_misaligned, push, pop;
    entry_t new_entry;

    assign st_ready = (count_q != 2'(depth));
    assign accept   = st_valid && st_ready;
    assign pop      = (count_q != 2'd0) && mem_ack;

    always_comb begin
        is_misaligned = 1'b0;
        case (st_size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = st_addr[0];
            SIZE_WORD: is_misaligned = (st_addr[1:0] != 2'b00);
            default:   is_misaligned = 1'b1;
        endcase
    end

    assign push = accept && !is_misaligned;

    // Lane placement: each byte lane picks its source byte and enable from size and offset.
    assign new_entry.addr = {st_addr[bus_size-1:2], 2'b00};
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                new_entry.wdata[8*gi +: 8] = st_data[8*gi +: 8];
                new_entry.be[gi]           = 1'b1;
                if (st_size == SIZE_BYTE) begin
                    new_entry.wdata[8*gi +: 8] = st_data[7:0];
                    new_entry.be[gi]           = (st_addr[1:0] == 2'(gi));
                end else if (st_size == SIZE_HALF) begin
                    new_entry.wdata[8*gi +: 8] = st_data[8*(gi%2) +: 8];
                    new_entry.be[gi]           = (st_addr[1] == 1'(gi/2));
                end
            end
        end
    endgenerate

    // Entry 0 is always the head; vacated slots are zeroed so an empty queue reads as zero.
    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        if (pop && push) begin
            fifo_d[0] = new_entry;
        end else if (pop) begin
            fifo_d[0] = fifo_q[1];
            fifo_d[1] = '0;
            count_d   = count_q - 2'd1;
        end else if (push) begin
            fifo_d[count_q[0]] = new_entry;
            count_d            = count_q + 2'd1;
        end
    end

    always_comb begin
        misalign_d = accept && is_misaligned;
        bad_addr_d = (accept && is_misaligned) ? st_addr : bad_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) fifo_q[i] <= '0;
            count_q    <= 2'd0;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            fifo_q     <= fifo_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign mem_req   = (count_q != 2'd0);
    assign mem_addr  = mem_req ? fifo_q[0].addr  : '0;
    assign mem_wdata = mem_req ? fifo_q[0].wdata : '0;
    assign mem_be    = mem_req ? fifo_q[0].be    : 4'b0000;
    assign misalign  = misalign_q;
    assign bad_addr  = bad_addr_q;

endmodule
